// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - bridges a 256-bit cache line port to a 4-beat 64-bit memory burst
// Optional CACHELINE_ADAPTOR_EARLY_RESP_EN: resp_o is raised combinationally on the last beat.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);
    localparam int BEATS = 4;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [1:0]                      beat_q, beat_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [BEATS-1:0][BURST_W-1:0]   rline_q, rline_d;
    logic [BEATS-1:0][BURST_W-1:0]   wline_q, wline_d;
    logic [BURST_W-1:0]              burst_q, burst_d;
    logic                            last_beat;
    logic                            unused_addr_lsb;

    assign last_beat       = resp_i && (beat_q == 2'd3);
    assign unused_addr_lsb = ^address_i[4:0];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        rline_d = rline_q;
        wline_d = wline_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (read_i && !write_i) begin
                    addr_d  = {address_i[ADDR_W-1:5], 5'b0};
                    beat_d  = 2'd0;
                    state_d = RD_BURST;
                end else if (write_i && !read_i) begin
                    addr_d  = {address_i[ADDR_W-1:5], 5'b0};
                    wline_d = line_i;
                    burst_d = line_i[BURST_W-1:0];
                    beat_d  = 2'd0;
                    state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    rline_d[beat_q] = burst_i;
                    beat_d          = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = DONE;
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    beat_d = beat_q + 2'd1;
                    // Preload the next beat so burst_o stays a plain register.
                    if (beat_q == 2'd3) state_d = DONE;
                    else                burst_d = wline_q[beat_q + 2'd1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            addr_q  <= '0;
            rline_q <= '0;
            wline_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            rline_q <= rline_d;
            wline_q <= wline_d;
            burst_q <= burst_d;
        end
    end

    assign read_o    = (state_q == RD_BURST);
    assign write_o   = (state_q == WR_BURST);
    assign address_o = addr_q;
    assign burst_o   = burst_q;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
    logic [BEATS-1:0][BURST_W-1:0] line_mux;

    always_comb begin
        line_mux = rline_q;
        if ((state_q == RD_BURST) && last_beat) line_mux[BEATS-1] = burst_i;
    end

    assign resp_o = ((state_q == RD_BURST) || (state_q == WR_BURST)) && last_beat;
    assign line_o = line_mux;
`else
    assign resp_o = (state_q == DONE);
    assign line_o = rline_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives four back-to-back beats starting in the current cycle; returns in the DONE cycle.
    task automatic read_burst(input string tag, input logic [3:0][63:0] exp);
        for (int i = 0; i < 4; i++) begin
            burst_i = exp[2'(i)];
            resp_i  = 1'b1;
            #1;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
            if (i == 3) begin
                chk({tag, "_early_resp"}, 256'(resp_o), 256'(1));
                chk({tag, "_early_line"}, line_o, exp);
            end else begin
                chk({tag, "_resp_mid"}, 256'(resp_o), 256'(0));
            end
`else
            chk({tag, "_resp_mid"}, 256'(resp_o), 256'(0));
`endif
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk({tag, "_read_o_done"}, 256'(read_o), 256'(0));
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
        chk({tag, "_resp_done"}, 256'(resp_o), 256'(0));
`else
        chk({tag, "_resp_done"}, 256'(resp_o), 256'(1));
        chk({tag, "_line_done"}, line_o, exp);
`endif
    endtask

    logic [3:0][63:0] rd1, rd2, wr1;

    initial begin
        rd1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wr1 = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
               64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        rd2 = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
               64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};

        rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        line_i = '0; burst_i = '0; resp_i = 1'b0;
        tick();
        tick();
        chk("rst_resp",    256'(resp_o),    256'(0));
        chk("rst_read",    256'(read_o),    256'(0));
        chk("rst_write",   256'(write_o),   256'(0));
        chk("rst_addr",    256'(address_o), 256'(0));
        chk("rst_burst",   256'(burst_o),   256'(0));
        chk("rst_line",    line_o,          256'(0));
        rst = 1'b0;

        // Line fill, consecutive beats
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        chk("rd1_read_o", 256'(read_o),    256'(1));
        chk("rd1_addr",   256'(address_o), 256'(32'h0000_1220));
        read_burst("rd1", rd1);
        read_i = 1'b0;
        tick();
        chk("rd1_after_resp", 256'(resp_o), 256'(0));
        chk("rd1_after_read", 256'(read_o), 256'(0));
        chk("rd1_line_hold",  line_o,       rd1);

        // Write-back with two idle cycles between beats
        address_i = 32'h0000_ABCF; write_i = 1'b1; line_i = wr1;
        tick();
        line_i = '0;
        chk("wr_write_o", 256'(write_o),   256'(1));
        chk("wr_addr",    256'(address_o), 256'(32'h0000_ABC0));
        chk("wr_burst0",  256'(burst_o),   256'(wr1[0]));
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1;
            #1;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
            chk("wr_resp_beat", 256'(resp_o), 256'(i == 3));
`else
            chk("wr_resp_beat", 256'(resp_o), 256'(0));
`endif
            tick();
            resp_i = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    chk("wr_burst_gap", 256'(burst_o), 256'(wr1[2'(i + 1)]));
                    chk("wr_write_gap", 256'(write_o), 256'(1));
                    chk("wr_resp_gap",  256'(resp_o),  256'(0));
                    if (g == 0) tick();
                end
                tick();
            end
        end
        chk("wr_done_write", 256'(write_o), 256'(0));
        chk("wr_done_burst", 256'(burst_o), 256'(wr1[3]));
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
        chk("wr_done_resp", 256'(resp_o), 256'(0));
`else
        chk("wr_done_resp", 256'(resp_o), 256'(1));
`endif
        write_i = 1'b0;
        tick();
        chk("wr_after_resp", 256'(resp_o), 256'(0));
        chk("wr_line_keep",  line_o,       rd1);

        // Both requests high, stray resp_i: nothing must happen
        read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("both_read",  256'(read_o),  256'(0));
            chk("both_write", 256'(write_o), 256'(0));
            chk("both_resp",  256'(resp_o),  256'(0));
        end
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        chk("both_line", line_o, rd1);
        tick();

        // Reset after two read beats, then a clean refill
        address_i = 32'h0000_0040; read_i = 1'b1;
        tick();
        resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
        tick();
        resp_i = 1'b0; burst_i = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_read_o", 256'(read_o), 256'(0));
        chk("abort_line",   line_o,       256'(0));
        tick();
        chk("refill_read_o", 256'(read_o),    256'(1));
        chk("refill_addr",   256'(address_o), 256'(32'h0000_0040));
        read_burst("refill", rd2);

        // read_i held through the DONE cycle, dropped one cycle later
        tick();
        read_i = 1'b0;
        chk("hold_read_o", 256'(read_o), 256'(0));
        chk("hold_resp",   256'(resp_o), 256'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_idle_read", 256'(read_o), 256'(0));
            chk("hold_idle_resp", 256'(resp_o), 256'(0));
        end
        chk("hold_line", line_o, rd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
